hyper_ram_scheduler: RTL and testbench

HYPER_RAM_SCHEDULER -- requirements
Module: hyper_ram_scheduler

---
 rtl/hyper_ram_pkg.sv | 37 +++
 rtl/hyper_ram_req_fifo.sv | 52 +++++
 rtl/hyper_ram_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_hyper_ram_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyper_ram_pkg.sv
// Shared FSM state type and HyperBus command/address word helpers for the
// HyperRAM request scheduler.
package hyper_ram_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_LOAD  = 3'd2,
        S_SETUP = 3'd3,
        S_XFER  = 3'd4,
        S_DONE  = 3'd5
    } sched_state_t;

    localparam int CA_W         = 48;
    localparam int CA_ADDR_W    = 23;
    localparam int CA_RW_BIT    = 47;
    localparam int CA_AS_BIT    = 46;
    localparam int CA_BURST_BIT = 45;
    localparam int CA_ROW_LSB   = 16;
    localparam int CA_ROW_W     = 20;
    localparam int CA_COL_W     = 3;

    // Upper word address lands in [35:16], the 3 low bits select the half-page word.
    function automatic logic [CA_W-1:0] build_ca(input logic rw,
                                                 input logic [CA_ADDR_W-1:0] addr,
                                                 input logic linear);
        logic [CA_W-1:0] ca;
        ca = '0;
        ca[CA_RW_BIT]    = rw;
        ca[CA_AS_BIT]    = 1'b0;
        ca[CA_BURST_BIT] = linear;
        ca[CA_ROW_LSB +: CA_ROW_W] = addr[CA_ADDR_W-1:CA_COL_W];
        ca[CA_COL_W-1:0] = addr[CA_COL_W-1:0];
        return ca;
    endfunction

endpackage

// File: rtl/hyper_ram_req_fifo.sv
// Per-channel synchronous request FIFO; head entry is visible combinationally
// so the scheduler can register it in the same cycle it pops.
module hyper_ram_req_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)
                count_q <= count_q + (AW+1)'(1);
            else if (pop_ok && !push_ok)
                count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/hyper_ram_scheduler.sv
// Multi-channel HyperRAM request scheduler: per-channel FIFOs, round-robin arbiter
// and transfer FSM. Defining HYPER_SCHED_TIMEOUT_EN adds the transfer watchdog.
import hyper_ram_pkg::*;

module hyper_ram_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int ADDR_W       = 23,
    parameter int LEN_W        = 11,
    parameter int QDEPTH       = 8,
    parameter int MAX_LEN      = 1280,
    parameter int LINEAR_BURST = 0,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                                    clock200,
    input  logic                                    reset,
    input  logic [NUM_CH-1:0]                       reqValid,
    input  logic [NUM_CH*ADDR_W-1:0]                reqAddr,
    input  logic [NUM_CH*LEN_W-1:0]                 reqLen,
    input  logic [NUM_CH-1:0]                       reqRw,
    output logic [NUM_CH-1:0]                       reqReady,
    output logic [NUM_CH*($clog2(QDEPTH)+1)-1:0]    queueCount,
    output logic                                    drvEnable,
    output logic [47:0]                             drvCaInfo,
    output logic [LEN_W-1:0]                        drvBytes,
    output logic                                    drvRwMode,
    input  logic                                    drvSetupDone,
    input  logic                                    drvProcessDone,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] grantCh,
    output logic                                    busy,
    output logic                                    doneValid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] doneCh,
    output logic                                    errorFlag
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EW = 1 + ADDR_W + LEN_W;
    localparam logic [LEN_W:0] MAX_L = (LEN_W+1)'(MAX_LEN);

    sched_state_t      state_q, state_d;
    logic [GW-1:0]     sel_q, sel_d, last_q, last_d, grant_q, grant_d, rr_win;
    logic [CA_W-1:0]   ca_q, ca_d;
    logic [LEN_W-1:0]  bytes_q, bytes_d, len_clamped;
    logic              rw_q, rw_d, en_q, en_d;
    logic [NUM_CH-1:0] empty_vec, pop_vec;
    logic [EW-1:0]     head [NUM_CH];
    logic              head_rw;
    logic [ADDR_W-1:0] head_addr;
    logic [LEN_W-1:0]  head_len;
    logic              wd_expire;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic          ch_full;
            logic [CW-1:0] ch_count;

            hyper_ram_req_fifo #(.WIDTH(EW), .DEPTH(QDEPTH)) u_fifo (
                .clk_i     (clock200),
                .srst_i    (reset),
                .push_i    (reqValid[gi]),
                .wr_data_i ({reqRw[gi], reqAddr[gi*ADDR_W +: ADDR_W], reqLen[gi*LEN_W +: LEN_W]}),
                .pop_i     (pop_vec[gi]),
                .rd_data_o (head[gi]),
                .full_o    (ch_full),
                .empty_o   (empty_vec[gi]),
                .count_o   (ch_count)
            );

            assign reqReady[gi]             = !ch_full;
            assign queueCount[gi*CW +: CW]  = ch_count;
        end
    endgenerate

    assign {head_rw, head_addr, head_len} = head[sel_q];
    assign len_clamped = ({1'b0, head_len} > MAX_L) ? MAX_L[LEN_W-1:0] : head_len;

    // Scan farthest-first so the nearest non-empty channel after last_q wins.
    always_comb begin
        int            idx;
        logic [GW-1:0] cand;
        rr_win = last_q;
        idx    = 0;
        cand   = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx  = (int'(last_q) + k) % NUM_CH;
            cand = GW'(idx);
            if (!empty_vec[cand]) rr_win = cand;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        grant_d = grant_q;
        ca_d    = ca_q;
        bytes_d = bytes_q;
        rw_d    = rw_q;
        en_d    = en_q;
        pop_vec = '0;
        unique case (state_q)
            S_IDLE: if (!(&empty_vec)) state_d = S_ARB;
            S_ARB: begin
                sel_d   = rr_win;
                last_d  = rr_win;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                pop_vec[sel_q] = 1'b1;
                grant_d = sel_q;
                ca_d    = build_ca(head_rw, CA_ADDR_W'(head_addr), LINEAR_BURST != 0);
                bytes_d = len_clamped;
                rw_d    = head_rw;
                if (head_len == '0) begin
                    state_d = S_DONE;
                end else begin
                    en_d    = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP, S_XFER: begin
                if (drvProcessDone || wd_expire) begin
                    en_d    = 1'b0;
                    state_d = S_DONE;
                end else if (state_q == S_SETUP && drvSetupDone) begin
                    state_d = S_XFER;
                end
            end
            S_DONE: begin
                en_d    = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock200) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            last_q  <= GW'(NUM_CH - 1);
            grant_q <= '0;
            ca_q    <= '0;
            bytes_q <= '0;
            rw_q    <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ca_q    <= ca_d;
            bytes_q <= bytes_d;
            rw_q    <= rw_d;
            en_q    <= en_d;
        end
    end

`ifdef HYPER_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    logic [WD_W-1:0] wd_q;
    logic            err_q;

    // Expire on the cycle whose edge would make the count reach TIMEOUT_CYC.
    assign wd_expire = (state_q == S_SETUP || state_q == S_XFER) &&
                       (wd_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock200) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else if (state_q == S_LOAD) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else if (state_q == S_SETUP || state_q == S_XFER) begin
            wd_q <= wd_q + WD_W'(1);
            if (wd_expire && !drvProcessDone) err_q <= 1'b1;
        end
    end

    assign errorFlag = (state_q == S_DONE) && err_q;
`else
    assign wd_expire = 1'b0;
    assign errorFlag = 1'b0;
`endif

    assign drvEnable = en_q;
    assign drvCaInfo = ca_q;
    assign drvBytes  = bytes_q;
    assign drvRwMode = rw_q;
    assign grantCh   = grant_q;
    assign doneCh    = grant_q;
    assign busy      = (state_q != S_IDLE);
    assign doneValid = (state_q == S_DONE);

endmodule

// File: tb/tb_hyper_ram_scheduler.sv
// Scoreboard bench for hyper_ram_scheduler: stimulus pushes expected completions,
// a monitor pops and checks them on every doneValid pulse.
module tb_hyper_ram_scheduler;
    localparam int NCH = 4;
    localparam int AW  = 23;
    localparam int LW  = 11;
    localparam int CW  = 4;
    localparam int GW  = 2;
`ifdef HYPER_SCHED_TIMEOUT_EN
    localparam bit WD       = 1'b1;
    localparam int PROC_LAT = 12;
`else
    localparam bit WD       = 1'b0;
    localparam int PROC_LAT = 20;
`endif

    logic              clock200 = 1'b0;
    logic              reset = 1'b1;
    logic [NCH-1:0]    reqValid = '0;
    logic [NCH*AW-1:0] reqAddr = '0;
    logic [NCH*LW-1:0] reqLen = '0;
    logic [NCH-1:0]    reqRw = '0;
    logic [NCH-1:0]    reqReady;
    logic [NCH*CW-1:0] queueCount;
    logic              drvEnable;
    logic [47:0]       drvCaInfo;
    logic [LW-1:0]     drvBytes;
    logic              drvRwMode;
    logic              drvSetupDone;
    logic              drvProcessDone;
    logic [GW-1:0]     grantCh;
    logic              busy;
    logic              doneValid;
    logic [GW-1:0]     doneCh;
    logic              errorFlag;

    typedef struct {
        int          ch;
        logic [47:0] ca;
        logic [LW-1:0] bytes;
        logic        rw;
        bit          en;
        bit          err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   drv_hang = 1'b0;

    hyper_ram_scheduler #(
        .NUM_CH(NCH), .ADDR_W(AW), .LEN_W(LW), .QDEPTH(8), .MAX_LEN(1280),
        .LINEAR_BURST(0), .TIMEOUT_CYC(16)
    ) dut (
        .clock200(clock200), .reset(reset),
        .reqValid(reqValid), .reqAddr(reqAddr), .reqLen(reqLen), .reqRw(reqRw),
        .reqReady(reqReady), .queueCount(queueCount),
        .drvEnable(drvEnable), .drvCaInfo(drvCaInfo), .drvBytes(drvBytes),
        .drvRwMode(drvRwMode), .drvSetupDone(drvSetupDone), .drvProcessDone(drvProcessDone),
        .grantCh(grantCh), .busy(busy), .doneValid(doneValid), .doneCh(doneCh),
        .errorFlag(errorFlag)
    );

    always #5 clock200 = ~clock200;
    always @(posedge clock200) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle=%0d want finish", cyc);
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [47:0] mk_ca(input logic rw, input logic [22:0] a);
        return {rw, 1'b0, 1'b0, 9'd0, a[22:3], 13'd0, a[2:0]};
    endfunction

    function automatic exp_t mk(input int ch, input logic [22:0] a, input logic [LW-1:0] l,
                                input logic rw, input int lat);
        exp_t e;
        e.ch = ch; e.ca = mk_ca(rw, a); e.bytes = (l > 11'd1280) ? 11'd1280 : l;
        e.rw = rw; e.en = (l != 0); e.err = 1'b0; e.lat = lat;
        return e;
    endfunction

    task automatic set_req(input int ch, input logic [22:0] a, input logic [LW-1:0] l, input logic rw);
        reqValid[ch] = 1'b1;
        reqAddr[ch*AW +: AW] = a;
        reqLen[ch*LW +: LW] = l;
        reqRw[ch] = rw;
    endtask

    task automatic push_one(input int ch, input logic [22:0] a, input logic [LW-1:0] l, input logic rw);
        set_req(ch, a, l, rw);
        @(negedge clock200);
        reqValid = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clock200);
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL drain_timeout: got pending=%0d want 0", sb.size());
        end
    endtask

    // Driver model: setup completes 3 cycles and the transfer PROC_LAT cycles after enable.
    initial begin : drv_model
        drvSetupDone = 1'b0;
        drvProcessDone = 1'b0;
        forever begin
            @(negedge clock200);
            if (drvEnable && !drv_hang) begin
                repeat (3) @(negedge clock200);
                drvSetupDone = 1'b1;
                @(negedge clock200);
                drvSetupDone = 1'b0;
                repeat (PROC_LAT - 4) @(negedge clock200);
                drvProcessDone = 1'b1;
                @(negedge clock200);
                drvProcessDone = 1'b0;
            end
        end
    end

    initial begin : monitor
        bit            en_prev = 1'b0;
        bit            en_seen = 1'b0;
        logic [47:0]   c_ca = '0;
        logic [LW-1:0] c_by = '0;
        logic          c_rw = 1'b0;
        int            c_cyc = 0;
        exp_t          e;
        forever begin
            @(negedge clock200);
            if (reset) begin
                en_prev = 1'b0;
                en_seen = 1'b0;
                continue;
            end
            if (drvEnable && !en_prev) begin
                c_ca = drvCaInfo; c_by = drvBytes; c_rw = drvRwMode;
                c_cyc = cyc; en_seen = 1'b1;
                $display("issue ch=%0d ca=%h bytes=%0d rw=%0d", grantCh, drvCaInfo, drvBytes, drvRwMode);
            end else if (drvEnable) begin
                chk("drv_stable", {drvRwMode, drvBytes, drvCaInfo}, {c_rw, c_by, c_ca});
            end
            if (doneValid) begin
                $display("done ch=%0d err=%0d", doneCh, errorFlag);
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got ch=%0d want no completion", doneCh);
                end else begin
                    e = sb.pop_front();
                    chk("done_ch", doneCh, e.ch);
                    chk("error_flag", errorFlag, e.err);
                    chk("enable_seen", en_seen, e.en);
                    chk("enable_low_in_done", drvEnable, 1'b0);
                    chk("ca_info", drvCaInfo, e.ca);
                    chk("bytes", drvBytes, e.bytes);
                    chk("rw_mode", drvRwMode, e.rw);
                    if (e.en) chk("ca_at_issue", c_ca, e.ca);
                    if (e.lat > 0) chk("latency", cyc - c_cyc, e.lat);
                end
                en_seen = 1'b0;
            end
            en_prev = drvEnable;
        end
    end

    initial begin : stim
        exp_t e;
        int   n;
        int   ndone;
        int   nen;
        logic [22:0] a;
        repeat (3) @(negedge clock200);
        chk("rst_drv", {drvEnable, drvRwMode, drvBytes, drvCaInfo}, 64'd0);
        chk("rst_status", {busy, doneValid, errorFlag, grantCh, doneCh}, 64'd0);
        chk("rst_qcount", queueCount, 64'd0);
        chk("rst_ready", reqReady, 64'hF);
        reset = 1'b0;
        @(negedge clock200);

        // Fairness: two requests on every channel, expected grant order 0,1,2,3,0,1,2,3.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NCH; c++) begin
                a = 23'(32'h1000 * (c + 1) + r * 8 + c);
                set_req(c, a, LW'(16 + 4 * c + r), 1'(c + r));
                sb.push_back(mk(c, a, LW'(16 + 4 * c + r), 1'(c + r), PROC_LAT + 1));
            end
            @(negedge clock200);
        end
        reqValid = '0;
        chk("fair_qcount", queueCount, 64'h2222);
        wait_drain(2000);

        // Single read on channel 1.
        e = '{ch: 1, ca: 48'h8000_2468_0005, bytes: 11'd64, rw: 1'b1, en: 1'b1, err: 1'b0, lat: PROC_LAT + 1};
        sb.push_back(e);
        push_one(1, 23'h12345, 11'd64, 1'b1);
        wait_drain(500);

        // Clamp on ch2, zero length on ch3.
        e = '{ch: 2, ca: 48'h000F_FFFF_0007, bytes: 11'd1280, rw: 1'b0, en: 1'b1, err: 1'b0, lat: PROC_LAT + 1};
        sb.push_back(e);
        e = '{ch: 3, ca: 48'h8000_0001_0000, bytes: 11'd0, rw: 1'b1, en: 1'b0, err: 1'b0, lat: 0};
        sb.push_back(e);
        set_req(2, 23'h7FFFFF, 11'd2000, 1'b0);
        set_req(3, 23'h000008, 11'd0, 1'b1);
        @(negedge clock200);
        reqValid = '0;
        wait_drain(500);

        // Stalled transfer on ch1 while ch0 is filled past its depth.
        drv_hang = 1'b1;
        e = '{ch: 1, ca: 48'h0000_0008_0000, bytes: 11'd32, rw: 1'b0, en: 1'b1, err: WD, lat: WD ? 16 : 0};
        sb.push_back(e);
        push_one(1, 23'h000040, 11'd32, 1'b0);
        n = 0;
        while (!drvEnable && n < 20) begin @(negedge clock200); n++; end
        chk("stall_enable", drvEnable, 1'b1);
        for (int i = 0; i < 9; i++) begin
            if (i == 7) chk("ready_before_full", reqReady[0], 1'b1);
            if (i == 8) chk("ready_low_after_8", reqReady[0], 1'b0);
            a = 23'(32'h200 + i * 9);
            set_req(0, a, LW'(4 + i), 1'(i));
            if (i < 8) sb.push_back(mk(0, a, LW'(4 + i), 1'(i), PROC_LAT + 1));
            @(negedge clock200);
        end
        reqValid = '0;
        chk("full_qcount", queueCount[CW-1:0], 64'd8);
        chk("full_ready", reqReady[0], 1'b0);
        if (!WD) begin
            drvProcessDone = 1'b1;
            @(negedge clock200);
            drvProcessDone = 1'b0;
        end
        n = 0;
        while (!doneValid && n < 40) begin @(negedge clock200); n++; end
        chk("stall_done_seen", doneValid, 1'b1);
        drv_hang = 1'b0;
        wait_drain(3000);

        // Reset in the middle of a transfer with another request still queued.
        set_req(2, 23'h000100, 11'd100, 1'b1);
        set_req(3, 23'h000200, 11'd50, 1'b0);
        @(negedge clock200);
        reqValid = '0;
        n = 0;
        while (!drvEnable && n < 20) begin @(negedge clock200); n++; end
        chk("mid_enable", drvEnable, 1'b1);
        repeat (6) @(negedge clock200);
        reset = 1'b1;
        @(negedge clock200);
        chk("rst_mid_enable", drvEnable, 1'b0);
        chk("rst_mid_qcount", queueCount, 64'd0);
        chk("rst_mid_status", {busy, doneValid}, 64'd0);
        @(negedge clock200);
        reset = 1'b0;
        ndone = 0;
        nen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock200);
            if (doneValid) ndone++;
            if (drvEnable) nen++;
        end
        chk("no_done_after_reset", ndone, 64'd0);
        chk("no_enable_after_reset", nen, 64'd0);
        chk("scoreboard_empty", sb.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
